// File: rtl/hazard_controller.sv
// hazard_controller: stall, flush and forwarding control for the five-stage MIPS pipeline.
// Resolves register dependencies between ID, EX, M and WB, tracks outstanding data-memory
// accesses and the HI/LO multiply/divide busy window, and defers exceptions that arrive
// while M is stalled until the stall releases.

module hazard_controller #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic       CLK,
    input  logic       RST,

    // ID stage
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic [7:0] ID_DP_Hazards,
    input  logic       ID_HiLoAccess,

    // EX stage
    input  logic [4:0] EX_Rs,
    input  logic [4:0] EX_Rt,
    input  logic [4:0] EX_Rw,
    input  logic       EX_RegWrite,
    input  logic       EX_MemRead,
    input  logic       EX_WantRsByEX,
    input  logic       EX_NeedRsByEX,
    input  logic       EX_WantRtByEX,
    input  logic       EX_NeedRtByEX,
    input  logic       EX_MulDivStart,
    input  logic       EX_MulDivIsDiv,
    input  logic       EX_Exception,

    // M stage
    input  logic [4:0] M_Rw,
    input  logic       M_RegWrite,
    input  logic       M_MemRead,
    input  logic       M_MemReq,
    input  logic       DMem_Ack,

    // WB stage
    input  logic [4:0] WB_Rw,
    input  logic       WB_RegWrite,

    // Pipeline register controls
    output logic       IF_Stall,
    output logic       ID_Stall,
    output logic       EX_Stall,
    output logic       M_Stall,
    output logic       ID_Flush,
    output logic       EX_Flush,

    // Forwarding selects: 00 regfile/pipeline, 01 M result, 10 WB result
    output logic [1:0] ID_FwdRs,
    output logic [1:0] ID_FwdRt,
    output logic [1:0] EX_FwdRs,
    output logic [1:0] EX_FwdRt,

    output logic       MulDiv_Busy
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_M    = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    // Memory access FSM encoding
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // A stage "matches" r when it writes r and r is not the hardwired zero register.
    function automatic logic reg_match(input logic wr, input logic [4:0] rw, input logic [4:0] r);
        return wr && (rw == r) && (r != 5'd0);
    endfunction

    // M has priority over WB because it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic m_hit, input logic wb_hit);
        logic [1:0] sel;
        sel = FWD_NONE;
        if (m_hit) begin
            sel = FWD_M;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------

    logic [0:0]       mem_state_q, mem_state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             exc_pend_q, exc_pend_d;

    // ------------------------------------------------------------------
    // Decoded hazard flags
    // ------------------------------------------------------------------

    logic need_rs_by_id;
    logic need_rt_by_id;
    logic need_rs_by_ex;
    logic need_rt_by_ex;

    // The Want flags only describe optional operand use; a missing forward there is
    // harmless, so stall decisions rest on the Need flags alone.
    logic unused_want_flags;

    assign need_rs_by_id = ID_DP_Hazards[6];
    assign need_rt_by_id = ID_DP_Hazards[4];
    assign need_rs_by_ex = ID_DP_Hazards[2];
    assign need_rt_by_ex = ID_DP_Hazards[0];

    assign unused_want_flags = ^{ID_DP_Hazards[7], ID_DP_Hazards[5], ID_DP_Hazards[3],
                                 ID_DP_Hazards[1], EX_WantRsByEX, EX_WantRtByEX};

    // ------------------------------------------------------------------
    // Combinational hazard evaluation (ungated by reset)
    // ------------------------------------------------------------------

    logic m_stall_raw;
    logic ex_stall_raw;
    logic id_stall_raw;
    logic ex_writes;
    logic ex_load_use;
    logic id_dep_stall;
    logic exc_flush;

    logic m_hit_id_rs, m_hit_id_rt, m_hit_ex_rs, m_hit_ex_rt;
    logic wb_hit_id_rs, wb_hit_id_rt, wb_hit_ex_rs, wb_hit_ex_rt;
    logic ex_hit_id_rs, ex_hit_id_rt;

    // Memory FSM: a request without ack enters WAIT; any ack returns to IDLE.
    always_comb begin
        mem_state_d = mem_state_q;
        m_stall_raw = 1'b0;
        case (mem_state_q)
            IDLE: begin
                if (M_MemReq && !DMem_Ack) begin
                    mem_state_d = WAIT;
                    m_stall_raw = 1'b1;
                end
            end
            WAIT: begin
                if (DMem_Ack) begin
                    mem_state_d = IDLE;
                end else begin
                    m_stall_raw = 1'b1;
                end
            end
            default: begin
                mem_state_d = IDLE;
            end
        endcase
    end

    // Register matches against the M and WB destinations.
    always_comb begin
        m_hit_id_rs  = reg_match(M_RegWrite, M_Rw, ID_Rs);
        m_hit_id_rt  = reg_match(M_RegWrite, M_Rw, ID_Rt);
        m_hit_ex_rs  = reg_match(M_RegWrite, M_Rw, EX_Rs);
        m_hit_ex_rt  = reg_match(M_RegWrite, M_Rw, EX_Rt);
        wb_hit_id_rs = reg_match(WB_RegWrite, WB_Rw, ID_Rs);
        wb_hit_id_rt = reg_match(WB_RegWrite, WB_Rw, ID_Rt);
        wb_hit_ex_rs = reg_match(WB_RegWrite, WB_Rw, EX_Rs);
        wb_hit_ex_rt = reg_match(WB_RegWrite, WB_Rw, EX_Rt);
    end

    // EX stalls on a load in M it must consume, or whenever M itself is stalled.
    always_comb begin
        ex_load_use  = (EX_NeedRsByEX && m_hit_ex_rs && M_MemRead) ||
                       (EX_NeedRtByEX && m_hit_ex_rt && M_MemRead);
        ex_stall_raw = m_stall_raw || ex_load_use;
    end

    // An EX instruction that is stalled will not advance, so it does not count as writing.
    always_comb begin
        ex_writes    = EX_RegWrite && !ex_stall_raw;
        ex_hit_id_rs = reg_match(ex_writes, EX_Rw, ID_Rs);
        ex_hit_id_rt = reg_match(ex_writes, EX_Rw, ID_Rt);
    end

    // ID stall: operand not yet available from EX/M, load-use, or HI/LO still busy.
    always_comb begin
        id_dep_stall = 1'b0;
        if (need_rs_by_id && ex_hit_id_rs) id_dep_stall = 1'b1;
        if (need_rt_by_id && ex_hit_id_rt) id_dep_stall = 1'b1;
        if (need_rs_by_id && m_hit_id_rs && M_MemRead) id_dep_stall = 1'b1;
        if (need_rt_by_id && m_hit_id_rt && M_MemRead) id_dep_stall = 1'b1;
        if (need_rs_by_ex && ex_hit_id_rs && EX_MemRead) id_dep_stall = 1'b1;
        if (need_rt_by_ex && ex_hit_id_rt && EX_MemRead) id_dep_stall = 1'b1;
        if (ID_HiLoAccess && (md_cnt_q != '0)) id_dep_stall = 1'b1;
        // The ID/EX register inserts its own bubble when ID stalls and EX does not.
        id_stall_raw = ex_stall_raw || id_dep_stall;
    end

    // Exceptions seen during a memory stall are parked and flushed once on release;
    // the held exception and the parked copy collapse into a single flush.
    always_comb begin
        exc_flush  = !m_stall_raw && (exc_pend_q || EX_Exception);
        exc_pend_d = m_stall_raw && (exc_pend_q || EX_Exception);
    end

    // HI/LO busy counter: reload on an issuing mult/div, otherwise count down to zero.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (EX_MulDivStart && !ex_stall_raw) begin
            md_cnt_d = EX_MulDivIsDiv ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Reset abandons any outstanding access, mult/div window and parked exception.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_state_q <= IDLE;
            md_cnt_q    <= '0;
            exc_pend_q  <= 1'b0;
        end else begin
            mem_state_q <= mem_state_d;
            md_cnt_q    <= md_cnt_d;
            exc_pend_q  <= exc_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all quiet while reset is asserted)
    // ------------------------------------------------------------------

    // Stall chain: each stage's stall also holds every upstream stage.
    always_comb begin
        M_Stall  = !RST && m_stall_raw;
        EX_Stall = !RST && ex_stall_raw;
        ID_Stall = !RST && id_stall_raw;
        IF_Stall = !RST && id_stall_raw;
    end

    // Flush wins over stall in the pipeline registers; stalls are still reported.
    always_comb begin
        ID_Flush = !RST && exc_flush;
        EX_Flush = !RST && exc_flush;
    end

    // Forwarding selects for both decode and execute operands.
    always_comb begin
        ID_FwdRs = FWD_NONE;
        ID_FwdRt = FWD_NONE;
        EX_FwdRs = FWD_NONE;
        EX_FwdRt = FWD_NONE;
        if (!RST) begin
            ID_FwdRs = fwd_sel(m_hit_id_rs, wb_hit_id_rs);
            ID_FwdRt = fwd_sel(m_hit_id_rt, wb_hit_id_rt);
            EX_FwdRs = fwd_sel(m_hit_ex_rs, wb_hit_ex_rs);
            EX_FwdRt = fwd_sel(m_hit_ex_rt, wb_hit_ex_rt);
        end
    end

    // Busy flag straight from the counter; reset clears the counter itself.
    always_comb begin
        MulDiv_Busy = !RST && (md_cnt_q != '0);
    end

endmodule
